// File: rtl/alu_sequencer.sv
// Microsequencer that runs a stored program of ALU operations on an external
// accumulator datapath: clear, then one issue/write pair per instruction.
module alu_sequencer #(
  parameter int unsigned PROG_DEPTH = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [6:0]        prog_data,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [2:0]        alu_op,
  output logic [3:0]        alu_a,
  output logic              acc_clear,
  output logic              acc_load,
  input  logic [7:0]        alu_result,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        result,
  output logic              wr_reject
);

  localparam logic [ADDR_W:0]   DepthW = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W:0]   LenOne = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PcOne  = ADDR_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StWrite,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        result_q, result_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [3:0]        alu_a_q, alu_a_d;
  logic              last_instr;

  // Program memory deliberately has no reset so a loaded program survives it.
  logic [6:0] mem [PROG_DEPTH];

  always_ff @(posedge clock) begin
    if (prog_we && (state_q == StIdle)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign last_instr = ({1'b0, pc_q} == (len_q - LenOne));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    result_d  = result_q;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    done      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = (length > DepthW) ? DepthW : length;
          pc_d    = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        acc_clear = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (len_q == '0) begin
          result_d = 8'h00;
          state_d  = StDone;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = abort ? StIdle : StWrite;
      end
      StWrite: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_load = 1'b1;
          if (last_instr) begin
            result_d = alu_result;
            state_d  = StDone;
          end else begin
            pc_d    = pc_q + PcOne;
            state_d = StIssue;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Fetch on entry to ISSUE so the ALU inputs are settled for the whole pair.
    if (state_d == StIssue) begin
      alu_op_d = mem[pc_d][6:4];
      alu_a_d  = mem[pc_d][3:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      len_q    <= '0;
      result_q <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      result_q <= result_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign wr_reject = prog_we && busy;
  assign pc        = pc_q;
  assign result    = result_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;

endmodule
